// File: rtl/fetch_decode_unit.sv
// fetch_decode_unit
//   Instruction sequencer for a combinational 8-bit ALU. It fetches 8-bit
//   instructions {opcode[7:4], operand[3:0]} from a synchronous program ROM,
//   decodes them, and commits the ALU result. It owns the PC and the
//   accumulator. Every instruction runs in a fixed FETCH/DECODE/EXECUTE loop.
//   HALT is terminal until reset.
//
// Parameters
//   ADDR_W     PC / ROM address width (>= 4); JMP target is zero-extended
//   ACC_RESET  accumulator value loaded on reset
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   run          in   1 = may leave FETCH, 0 = hold in FETCH
//   imem_addr    out  ROM address (= pc)
//   imem_rdata   in   ROM data, valid the cycle after imem_addr
//   alu_opcode   out  ir[7:4]
//   alu_operand  out  ir[3:0]
//   alu_acc      out  accumulator to the ALU
//   alu_result   in   ALU combinational result
//   acc          out  architectural accumulator
//   pc           out  program counter
//   halted       out  sticky HALT flag
module fetch_decode_unit #(
  parameter int unsigned ADDR_W    = 4,
  parameter logic [7:0]  ACC_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic [3:0]        alu_opcode,
  output logic [3:0]        alu_operand,
  output logic [7:0]        alu_acc,
  input  logic [7:0]        alu_result,
  output logic [7:0]        acc,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_ADDI = 4'h0,
    OP_SUBI = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_JMP  = 4'h4,
    OP_HALT = 4'hF
  } opcode_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [7:0]        r_ir;
  logic [7:0]        w_ir_nxt;
  logic [7:0]        r_acc;
  logic [7:0]        w_acc_nxt;
  logic              r_halted;
  logic              w_halted_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_jmp_target;

  // Increment wraps naturally at 2^ADDR_W.
  assign w_pc_inc     = r_pc + ADDR_W'(1);
  assign w_jmp_target = ADDR_W'(r_ir[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_ir     <= '0;
      r_acc    <= ACC_RESET;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_acc    <= w_acc_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_acc_nxt    = r_acc;
    w_halted_nxt = r_halted;

    unique case (r_state)
      S_FETCH: begin
        if (run) begin
          w_state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        // The ROM answers the address held during FETCH; pc is unchanged
        // so imem_addr stays stable here.
        w_ir_nxt    = imem_rdata;
        w_state_nxt = S_EXECUTE;
      end

      S_EXECUTE: begin
        w_state_nxt = S_FETCH;
        case (r_ir[7:4])
          OP_ADDI, OP_SUBI, OP_AND, OP_OR: begin
            w_acc_nxt = alu_result;
            w_pc_nxt  = w_pc_inc;
          end
          OP_JMP: begin
            w_pc_nxt = w_jmp_target;
          end
          OP_HALT: begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = S_HALT;
          end
          default: begin
            w_pc_nxt = w_pc_inc;
          end
        endcase
      end

      S_HALT: begin
        w_state_nxt = S_HALT;
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign acc         = r_acc;
  assign alu_acc     = r_acc;
  assign alu_opcode  = r_ir[7:4];
  assign alu_operand = r_ir[3:0];
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Testbench for fetch_decode_unit: synchronous ROM and combinational ALU
// models, an instruction-level reference model feeding an expectation queue,
// and direct checks for reset, stall and the 6-bit address variant.
module tb_fetch_decode_unit;

  logic       clk;
  logic       rst_n;
  logic       run;

  logic [3:0] imem_addr;
  logic [7:0] imem_rdata;
  logic [3:0] alu_opcode;
  logic [3:0] alu_operand;
  logic [7:0] alu_acc;
  logic [7:0] alu_result;
  logic [7:0] acc;
  logic [3:0] pc;
  logic       halted;

  logic [5:0] imem_addr6;
  logic [7:0] imem_rdata6;
  logic [3:0] alu_opcode6;
  logic [3:0] alu_operand6;
  logic [7:0] alu_acc6;
  logic [7:0] alu_result6;
  logic [7:0] acc6;
  logic [5:0] pc6;
  logic       halted6;

  logic [7:0] rom  [0:15];
  logic [7:0] rom6 [0:63];

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic [3:0] pc;
    logic [7:0] acc;
    logic       halted;
  } exp_t;

  exp_t exp_q[$];

  fetch_decode_unit #(.ADDR_W(4), .ACC_RESET(8'h00)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .alu_opcode  (alu_opcode),
    .alu_operand (alu_operand),
    .alu_acc     (alu_acc),
    .alu_result  (alu_result),
    .acc         (acc),
    .pc          (pc),
    .halted      (halted)
  );

  fetch_decode_unit #(.ADDR_W(6), .ACC_RESET(8'h00)) u_dut6 (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_addr   (imem_addr6),
    .imem_rdata  (imem_rdata6),
    .alu_opcode  (alu_opcode6),
    .alu_operand (alu_operand6),
    .alu_acc     (alu_acc6),
    .alu_result  (alu_result6),
    .acc         (acc6),
    .pc          (pc6),
    .halted      (halted6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs: data appears the cycle after the address.
  always @(posedge clk) begin
    imem_rdata  <= rom[imem_addr];
    imem_rdata6 <= rom6[imem_addr6];
  end

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] opnd,
                                       input logic [7:0] a);
    case (op)
      4'h0:    return a + {4'h0, opnd};
      4'h1:    return a - {4'h0, opnd};
      4'h2:    return a & {4'h0, opnd};
      4'h3:    return a | {4'h0, opnd};
      default: return a;
    endcase
  endfunction

  assign alu_result  = alu_f(alu_opcode, alu_operand, alu_acc);
  assign alu_result6 = alu_f(alu_opcode6, alu_operand6, alu_acc6);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    run   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Architectural reference: one entry per completed instruction.
  task automatic build_expect(input int unsigned n);
    logic [3:0] m_pc;
    logic [7:0] m_acc;
    logic       m_halt;
    logic [7:0] ins;
    exp_t       e;
    m_pc   = 4'h0;
    m_acc  = 8'h00;
    m_halt = 1'b0;
    for (int unsigned k = 0; k < n; k++) begin
      if (!m_halt) begin
        ins = rom[m_pc];
        case (ins[7:4])
          4'h0: begin m_acc = m_acc + {4'h0, ins[3:0]}; m_pc = m_pc + 4'h1; end
          4'h1: begin m_acc = m_acc - {4'h0, ins[3:0]}; m_pc = m_pc + 4'h1; end
          4'h2: begin m_acc = m_acc & {4'h0, ins[3:0]}; m_pc = m_pc + 4'h1; end
          4'h3: begin m_acc = m_acc | {4'h0, ins[3:0]}; m_pc = m_pc + 4'h1; end
          4'h4: m_pc = ins[3:0];
          4'hF: m_halt = 1'b1;
          default: m_pc = m_pc + 4'h1;
        endcase
      end
      e.pc     = m_pc;
      e.acc    = m_acc;
      e.halted = m_halt;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_prog(input string name, input int unsigned n);
    exp_t e;
    do_reset();
    build_expect(n);
    run = 1'b1;
    while (exp_q.size() > 0) begin
      repeat (3) @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk({name, ".pc"},      {28'h0, pc},   {28'h0, e.pc});
      chk({name, ".addr"},    {28'h0, imem_addr}, {28'h0, e.pc});
      chk({name, ".acc"},     {24'h0, acc},  {24'h0, e.acc});
      chk({name, ".alu_acc"}, {24'h0, alu_acc}, {24'h0, e.acc});
      chk({name, ".halted"},  {31'h0, halted}, {31'h0, e.halted});
    end
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    fill_rom(8'h80);
    for (int i = 0; i < 64; i++) rom6[i] = 8'h80;
    rom6[0]  = 8'h4A;
    rom6[10] = 8'h01;
    #12;

    // Reset state
    do_reset();
    #1;
    chk("rst.pc",     {28'h0, pc},     32'h0);
    chk("rst.acc",    {24'h0, acc},    32'h0);
    chk("rst.halted", {31'h0, halted}, 32'h0);
    chk("rst.opcode", {28'h0, alu_opcode}, 32'h0);

    // Basic program with HALT, plus frozen state after HALT
    fill_rom(8'h80);
    rom[0] = 8'h05; rom[1] = 8'h03; rom[2] = 8'h14; rom[3] = 8'hF0;
    run_prog("basic", 6);
    chk("basic.pc_final",  {28'h0, pc},  32'h3);
    chk("basic.acc_final", {24'h0, acc}, 32'h04);

    // 8-bit wrap on ADDI/SUBI and logic ops
    fill_rom(8'h80);
    rom[0] = 8'h12; rom[1] = 8'h03; rom[2] = 8'h11; rom[3] = 8'h11;
    rom[4] = 8'h3A; rom[5] = 8'h25; rom[6] = 8'hF0;
    run_prog("wrap", 8);
    chk("wrap.acc_final", {24'h0, acc}, 32'h05);

    // JMP
    fill_rom(8'h80);
    rom[0] = 8'h4A; rom[10] = 8'h07; rom[11] = 8'hF0;
    run_prog("jmp", 4);

    // Runaway NOPs: pc wraps 15 -> 0, acc untouched
    fill_rom(8'h80);
    run_prog("runaway", 18);
    chk("runaway.pc_final", {28'h0, pc}, 32'h2);

    // Async reset in the middle of EXECUTE with acc=0x37
    fill_rom(8'h80);
    rom[0] = 8'h0F; rom[1] = 8'h0F; rom[2] = 8'h0F; rom[3] = 8'h0A; rom[4] = 8'h05;
    run_prog("pre_rst", 4);
    chk("pre_rst.acc37", {24'h0, acc}, 32'h37);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.pc",      {28'h0, pc},     32'h0);
    chk("midrst.acc",     {24'h0, acc},    32'h0);
    chk("midrst.halted",  {31'h0, halted}, 32'h0);
    chk("midrst.opcode",  {28'h0, alu_opcode},  32'h0);
    chk("midrst.operand", {28'h0, alu_operand}, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst.acc_hold", {24'h0, acc}, 32'h0);

    // Stall with run=0, then drop run during DECODE
    fill_rom(8'h80);
    rom[0] = 8'h05;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("stall.pc",      {28'h0, pc},          32'h0);
    chk("stall.opcode",  {28'h0, alu_opcode},  32'h0);
    chk("stall.operand", {28'h0, alu_operand}, 32'h0);
    chk("stall.acc",     {24'h0, acc},         32'h0);
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("drop.pc",  {28'h0, pc},  32'h1);
    chk("drop.acc", {24'h0, acc}, 32'h05);
    repeat (6) @(posedge clk);
    #1;
    chk("park.pc",  {28'h0, pc},  32'h1);
    chk("park.acc", {24'h0, acc}, 32'h05);

    // ADDR_W=6 instance: JMP target zero-extended
    do_reset();
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("w6.jmp_pc", {26'h0, pc6}, 32'h0A);
    repeat (3) @(posedge clk);
    #1;
    chk("w6.pc_next", {26'h0, pc6},  32'h0B);
    chk("w6.acc",     {24'h0, acc6}, 32'h01);
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
